// File: rtl/countdown_display_ctrl.sv
// countdown_display_ctrl
//
// Front-panel controller for a countdown game. It watches the start button
// and the timer's expired flag, issues a one-cycle start pulse to the
// countdown timer, and multiplexes a 4-digit active-low 7-segment display:
// dashes while idle, the remaining seconds while running, and a blinking
// "donE" once time has run out.
//
// Ports:
//   clk        in   1  system clock, rising-edge
//   rst_n      in   1  synchronous active-low reset
//   start_btn  in   1  debounced start button level
//   count      in   5  remaining seconds from the countdown timer (0..31)
//   gameover   in   1  countdown-expired level from the countdown timer
//   trigger    out  1  one-cycle start pulse to the countdown timer
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   an         out  4  digit anodes, active-low, an[0] = rightmost digit
//   dp         out  1  decimal point, active-low, always off

`timescale 1ns/1ps

module countdown_display_ctrl #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [4:0] count,
    input  logic       gameover,
    output logic       trigger,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    logic [1:0]         state_q, state_d;
    logic               trigger_q, trigger_d;
    logic               start_prev_q, start_prev_d;
    logic               go_prev_q, go_prev_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         scan_idx_q, scan_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_vis_q, blink_vis_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q;

    logic       start_rise;
    logic       go_rise;
    logic [1:0] tens;
    logic [3:0] ones;
    logic [3:0] digit_an;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // The start "previous sample" powers up as 1 so a button that is already
    // held when reset releases is not mistaken for a fresh press.
    assign start_rise = start_btn & ~start_prev_q;
    assign go_rise    = gameover  & ~go_prev_q;

    // Control FSM. A start press in IDLE or OVER launches the timer; while
    // running only a fresh gameover edge matters, and it wins over a
    // simultaneous start press. The blink counter only runs while staying
    // in OVER, so every entry into OVER starts on a full visible phase.
    always_comb begin
        state_d      = state_q;
        trigger_d    = 1'b0;
        start_prev_d = start_btn;
        go_prev_d    = gameover;
        blink_cnt_d  = '0;
        blink_vis_d  = 1'b1;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d   = S_RUNNING;
                    trigger_d = 1'b1;
                end
            end
            S_RUNNING: begin
                if (go_rise) begin
                    state_d = S_OVER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_OVER && state_d == S_OVER) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_ONE;
                blink_vis_d = blink_vis_q;
            end
        end
    end

    // Digit scan: the index steps once per SCAN_DIV clocks, free-running in
    // every state so the multiplex rate never changes.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_ONE;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    // Split the 0..31 seconds value into tens and ones with compares rather
    // than a divider.
    always_comb begin
        tens = 2'd0;
        ones = count[3:0];
        if (count >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(count - 5'd30);
        end else if (count >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(count - 5'd20);
        end else if (count >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(count - 5'd10);
        end
    end

    // Display content for the digit currently being scanned. A blank digit
    // keeps all anodes off as well as all segments.
    always_comb begin
        digit_an = ~(4'b0001 << scan_idx_q);
        seg_d    = SEG_BLANK;
        an_d     = 4'b1111;

        case (state_q)
            S_IDLE: begin
                seg_d = SEG_DASH;
                an_d  = digit_an;
            end
            S_RUNNING: begin
                if (scan_idx_q == 2'd0) begin
                    seg_d = digit_to_seg(ones);
                    an_d  = digit_an;
                end else if (scan_idx_q == 2'd1 && tens != 2'd0) begin
                    seg_d = digit_to_seg({2'b00, tens});
                    an_d  = digit_an;
                end
            end
            S_OVER: begin
                if (blink_vis_q) begin
                    an_d = digit_an;
                    case (scan_idx_q)
                        2'd0:    seg_d = SEG_E;
                        2'd1:    seg_d = SEG_N;
                        2'd2:    seg_d = SEG_O;
                        default: seg_d = SEG_D;
                    endcase
                end
            end
            default: begin
                seg_d = SEG_BLANK;
                an_d  = 4'b1111;
            end
        endcase
    end

    // All state and outputs registered; reset blanks the display and returns
    // to IDLE without emitting a trigger.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            trigger_q    <= 1'b0;
            start_prev_q <= 1'b1;
            go_prev_q    <= 1'b0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= 2'd0;
            blink_cnt_q  <= '0;
            blink_vis_q  <= 1'b1;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            trigger_q    <= trigger_d;
            start_prev_q <= start_prev_d;
            go_prev_q    <= go_prev_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_vis_q  <= blink_vis_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= 1'b1;
        end
    end

    assign trigger = trigger_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;

endmodule

// File: doc/countdown_display_ctrl.md
COUNTDOWN_DISPLAY_CTRL -- requirements
Module: countdown_display_ctrl

Interface
REQ-001 SCAN_DIV, 100000, clk cycles per 7-segment digit scan step (1 kHz digit rate at 100 MHz).
REQ-002 BLINK_DIV, 25000000, clk cycles per blink phase toggle in OVER.
REQ-003 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start_btn  input  1  debounced start button level, synchronous to clk.
REQ-006 count  input  5  remaining seconds from the countdown timer, 0..31.
REQ-007 gameover  input  1  countdown-expired level from the countdown timer.
REQ-008 trigger  output  1  one-cycle start pulse to the countdown timer.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an  output  4  digit anodes, active-low, an[0] is the rightmost digit.
REQ-011 dp  output  1  decimal point, active-low, held 1.

Function
REQ-012 The block SHALL implement three states: IDLE, RUNNING, OVER.
REQ-013 start_btn rising edge SHALL be start_btn=1 with the registered previous sample=0; the previous sample resets to 1, so a button held through reset never triggers.
REQ-014 In IDLE or OVER, a start_btn rising edge SHALL drive trigger=1 for exactly the next cycle and move to RUNNING in that same cycle.
REQ-015 In RUNNING, start_btn edges SHALL be ignored; trigger SHALL stay 0.
REQ-016 gameover rising edge is gameover=1 with previous sample=0; the previous sample resets to 0.
REQ-017 In RUNNING, a gameover rising edge SHALL move to OVER; a gameover level held high without an edge SHALL NOT.
REQ-018 A gameover rising edge and a start_btn rising edge in the same RUNNING cycle SHALL move to OVER with no trigger.
REQ-019 gameover edges in IDLE and OVER SHALL be ignored.
REQ-020 A 2-bit scan index SHALL advance modulo 4 each time a scan counter reaches SCAN_DIV-1; the counter then wraps to 0.
REQ-021 The active digit SHALL drive an low at bit[index] only; all other anode bits are high. A blank digit drives all an high and seg=7'h7F.
REQ-022 IDLE display SHALL be dash (seg=7'b0111111) on all four digits.
REQ-023 RUNNING display SHALL be digit0 = count mod 10 and digit1 = count/10 (0..3); digit1 is blank when count<10; digits 2 and 3 are blank.
REQ-024 Digit codes 0..9 SHALL be the standard active-low patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
REQ-025 OVER display SHALL show "donE", with d=7'b0100001 on digit3, o=7'b0100011 on digit2, n=7'b0101011 on digit1, E=7'b0000110 on digit0.
REQ-026 In OVER, a blink counter SHALL toggle the phase every BLINK_DIV cycles.
REQ-027 The blink counter SHALL reset to 0, with the phase set to visible, on every OVER entry.
REQ-028 During the invisible phase, all four digits SHALL be blank.
REQ-029 seg, an and dp SHALL be registered, with one cycle of latency from state, index and count.
REQ-030 trigger SHALL be registered; it SHALL be high for one cycle only per accepted edge.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, trigger=0, an=4'b1111, seg=7'h7F, dp=1, scan index and both counters=0, blink phase=visible, start previous sample=1, gameover previous sample=0.
REQ-032 Reset asserted mid-RUNNING or mid-OVER SHALL take effect on the next clock edge, with no trigger emitted.

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-033 Reset, then idle 16 cycles: an cycles 1110, 1101, 1011, 0111, with each step lasting 4 cycles; seg=7'b0111111 on every digit; trigger=0.
REQ-034 start_btn held high through reset and for 10 cycles after: trigger stays 0. Then drop start_btn, raise it: trigger=1 for exactly 1 cycle; state=RUNNING.
REQ-035 RUNNING with count=23: digit0 seg=7'b0110000, digit1 seg=7'b0100100, digits 2 and 3 blank. With count=7: digit1 blank, digit0=7'b1111000.
REQ-036 RUNNING: start_btn pulses produce no trigger. gameover 0->1 -> OVER; "donE" visible for 8 cycles, then blank for 8 cycles, repeating.
REQ-037 OVER: start_btn edge -> trigger pulse, state=RUNNING. gameover held at 1 for 2 more cycles, then 0, then 1 -> OVER only on the final rise.
REQ-038 Same-cycle gameover rise and start_btn rise in RUNNING -> OVER, trigger=0. rst_n=0 one cycle in OVER -> REQ-031 values next cycle.
